// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry look-ahead adder.
// Holds the controller state encoding and the width of one slice.
package cla_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry look-ahead slice.
// Produces the nibble sum and every internal carry so the caller can derive overflow.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic [3:0] c
);

  logic [3:0] g;
  logic [3:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded directly from generate/propagate terms, not rippled.
  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c[2:0], cin};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract built from one 4-bit look-ahead slice.
// One nibble is processed per cycle, LSB first, with the slice carry registered between nibbles.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / NIB;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t                      state;
  logic [IDXW-1:0]             idx;
  logic                        carry;
  logic [NSLICE-1:0][NIB-1:0]  op_a;
  logic [NSLICE-1:0][NIB-1:0]  op_b;
  logic [NSLICE-1:0][NIB-1:0]  sum_r;

  logic [NIB-1:0] sl_sum;
  logic [NIB-1:0] sl_c;

  cla4_slice u_slice (
    .a   (op_a[idx]),
    .b   (op_b[idx]),
    .cin (carry),
    .sum (sl_sum),
    .c   (sl_c)
  );

  assign sum = sum_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      sum_r     <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtraction is a + ~b + 1, so the inverted operand is latched here.
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub | cin;
            sum_r    <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= sl_sum;
          carry      <= sl_c[3];
          if (idx == LAST) begin
            cout      <= sl_c[3];
            ovf       <= sl_c[2] ^ sl_c[3];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
